// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte-wide UART transmitter among NUM_REQ sources,
// with a watchdog that aborts a byte if the transmitter never reports tx_done.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int IDX_W          = 2,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TO_W           = 20,
    parameter int GAP_CYCLES     = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*8-1:0]   req_data,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   tx_en,
    output logic [7:0]             tx_data,
    input  logic                   tx_done,
    output logic                   busy,
    output logic [IDX_W-1:0]       grant_id,
    output logic                   timeout_pulse,
    output logic                   err_flag,
    input  logic                   err_clr
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [IDX_W:0]     LP_NUM      = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0]   LP_LAST_RST = IDX_W'(NUM_REQ - 1);
    localparam logic [TO_W-1:0]    LP_TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0]   LP_GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_GAP
    } state_t;

    state_t               r_state;
    logic [IDX_W-1:0]     r_last;
    logic [IDX_W-1:0]     r_grant;
    logic [TO_W-1:0]      r_wdog;
    logic [GAP_W-1:0]     r_gap;
    logic [NUM_REQ-1:0]   r_ack;
    logic                 r_tx_en;
    logic [7:0]           r_tx_data;
    logic                 r_busy;
    logic                 r_timeout;
    logic                 r_err;

    logic [IDX_W-1:0]     w_sel;
    logic                 w_any;
    logic [IDX_W:0]       w_pos;
    logic [IDX_W-1:0]     w_idx;

    // Search starts just after the last served requester so the pointer rotates.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        w_sel = '0;
        w_any = 1'b0;
        w_pos = '0;
        w_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_pos = {1'b0, r_last} + (IDX_W+1)'(k);
            if (w_pos >= LP_NUM) begin
                w_pos = w_pos - LP_NUM;
            end
            w_idx = w_pos[IDX_W-1:0];
            if (!w_any && req[w_idx]) begin
                w_any = 1'b1;
                w_sel = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_last    <= LP_LAST_RST;
            r_grant   <= '0;
            r_wdog    <= '0;
            r_gap     <= '0;
            r_ack     <= '0;
            r_tx_en   <= 1'b0;
            r_tx_data <= 8'h00;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_ack     <= '0;
            r_timeout <= 1'b0;
            // NOTE: non-blocking assignments; a later one in this block wins, which gives an abort's set priority over err_clr.
            if (err_clr) begin
                r_err <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant   <= w_sel;
                        r_tx_data <= req_data[{w_sel, 3'b000} +: 8];
                        r_busy    <= 1'b1;
                        r_tx_en   <= 1'b1;
                        r_state   <= S_START;
                    end
                end

                S_START: begin
                    r_tx_en <= 1'b0;
                    r_wdog  <= '0;
                    r_gap   <= '0;
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    if (tx_done) begin
                        r_ack[r_grant] <= 1'b1;
                        r_last         <= r_grant;
                        r_state        <= S_GAP;
                    end else if (r_wdog == LP_TO_LAST) begin
                        r_ack[r_grant] <= 1'b1;
                        r_timeout      <= 1'b1;
                        r_err          <= 1'b1;
                        r_last         <= r_grant;
                        r_state        <= S_GAP;
                    end else begin
                        r_wdog <= r_wdog + TO_W'(1);
                    end
                end

                S_GAP: begin
                    // Idle spacing keeps tx_en low long enough for the transmitter's edge detector.
                    if (r_gap == LP_GAP_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ack           = r_ack;
    assign tx_en         = r_tx_en;
    assign tx_data       = r_tx_data;
    assign busy          = r_busy;
    assign grant_id      = r_grant;
    assign timeout_pulse = r_timeout;
    assign err_flag      = r_err;

endmodule
